aer_output_tx: RTL and testbench

AER output transmitter for the neural accelerator. It drains 24-bit spike events from the output event FIFO (read side: rd_en/empty/registered dout) and drives each event onto the off-chip asynchronous AER bus using a 4-phase req/ack handshake. It is the outbound counterpart of the aer_input receive path. The incoming ack is synchronised, handshake stalls are detected with a timeout, and sent events are counted.

---
 rtl/aer_output_tx.sv | 180 ++++++++++++++++++
 tb/tb_aer_output_tx.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_output_tx.sv
// AER output transmitter: drains spike events from the output event FIFO and
// drives each one onto the off-chip asynchronous AER bus with a 4-phase
// req/ack handshake. The incoming ack is synchronised, stalled handshakes are
// aborted by a wait timeout, and completed events are counted.
//
// Handshake summary (all signals as seen at the pins of this block):
//   FIFO side : fifo_rd_en is a one-cycle pop strobe issued only when
//               fifo_empty was low in IDLE; fifo_dout is taken one cycle later.
//   AER side  : aer_addr is stable before aer_req rises (SETUP_CYC cycles),
//               req rises -> wait ack high -> req falls -> wait ack low.
//               aer_addr only changes in LATCH, so it never moves while req or
//               the synchronised ack is high.
module aer_output_tx #(
  parameter int DATA_W    = 24,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] aer_addr,
  output logic              aer_req,
  input  logic              aer_ack,
  output logic              busy,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  sent_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LATCH = 3'd2,
    S_SETUP = 3'd3,
    S_REQ   = 3'd4,
    S_REL   = 3'd5
  } state_e;

  // Last count values of the setup and wait counters.
  localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic              ack_meta_q;
  logic              ack_s_q;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic [3:0]        setup_cnt_q, setup_cnt_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              wait_last;
  logic              timeout;

  assign wait_last = (wait_cnt_q == WAIT_LAST);

  // Two-flop synchroniser for the asynchronous bus acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= aer_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a high ack in IDLE blocks new work until the bus is released.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tx_en && !fifo_empty && !ack_s_q) state_d = S_RD;
      S_RD:    state_d = S_LATCH;
      S_LATCH: state_d = S_SETUP;
      S_SETUP: if (setup_cnt_q == SETUP_LAST) state_d = S_REQ;
      S_REQ: begin
        if (ack_s_q)        state_d = S_REL;
        else if (wait_last) state_d = S_IDLE;
      end
      S_REL: begin
        if (!ack_s_q)       state_d = S_IDLE;
        else if (wait_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    fifo_rd_en = (state_q == S_RD);
    busy       = (state_q != S_IDLE);
    dbg_state  = state_q;
  end

  // Datapath: address latch, registered req, setup/wait counters, flags, count.
  always_comb begin
    addr_d      = addr_q;
    req_d       = req_q;
    setup_cnt_d = setup_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    sent_d      = sent_q;
    timeout     = 1'b0;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      S_LATCH: begin
        addr_d      = fifo_dout;
        setup_cnt_d = '0;
      end
      S_SETUP: begin
        setup_cnt_d = setup_cnt_q + 4'd1;
        if (setup_cnt_q == SETUP_LAST) begin
          req_d      = 1'b1;
          wait_cnt_d = '0;
        end
      end
      S_REQ: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (ack_s_q) begin
          req_d      = 1'b0;
          wait_cnt_d = '0;
        end else if (wait_last) begin
          req_d   = 1'b0;
          timeout = 1'b1;
        end
      end
      S_REL: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (!ack_s_q) begin
          sent_d = sent_q + CNT_W'(1);
        end else if (wait_last) begin
          timeout = 1'b1;
        end
      end
      default: ;
    endcase
    // A timeout in the same cycle as err_clr leaves the flag set.
    if (timeout) err_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      req_q       <= 1'b0;
      setup_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      sent_q      <= '0;
    end else begin
      addr_q      <= addr_d;
      req_q       <= req_d;
      setup_cnt_q <= setup_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      sent_q      <= sent_d;
    end
  end

  assign aer_addr    = addr_q;
  assign aer_req     = req_q;
  assign err_timeout = err_q;
  assign sent_count  = sent_q;

endmodule

// File: tb/tb_aer_output_tx.sv
// Testbench for aer_output_tx: FIFO model, AER responder model, scoreboard of
// expected bus words in push order, directed sequences, a vector table and a
// randomized burst.
`timescale 1ns/1ps
module tb_aer_output_tx;

  localparam int DATA_W    = 24;
  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 16;
  localparam int CNT_W     = 16;

  localparam int R_NORMAL = 0;
  localparam int R_NONE   = 1;
  localparam int R_STUCK  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tx_en = 1'b0;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] aer_addr;
  logic              aer_req;
  logic              aer_ack;
  logic              busy;
  logic              err_timeout;
  logic              err_clr = 1'b0;
  logic [CNT_W-1:0]  sent_count;
  logic [2:0]        dbg_state;

  aer_output_tx #(
    .DATA_W(DATA_W), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .aer_addr(aer_addr),
    .aer_req(aer_req), .aer_ack(aer_ack), .busy(busy),
    .err_timeout(err_timeout), .err_clr(err_clr), .sent_count(sent_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int exp_sent = 0;
  int ack_low_cnt = 0;
  int resp_mode = R_NORMAL;
  int ack_dly = 3;
  int rel_dly = 3;
  logic prev_req = 1'b0;
  logic prev_rd  = 1'b0;
  logic [DATA_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model (registered dout) ----------------
  logic [DATA_W-1:0] fifo_mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en && (push_cnt != pop_cnt)) begin
      fifo_dout <= fifo_mem[pop_cnt % 256];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  task automatic push_ev(input logic [DATA_W-1:0] v);
    fifo_mem[push_cnt % 256] = v;
    push_cnt++;
    exp_q.push_back(v);
  endtask

  // ---------------- AER responder model ----------------
  initial begin
    int c;
    c = 0;
    aer_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_mode == R_NONE) begin
        aer_ack = 1'b0;
        c = 0;
      end else if (aer_req && !aer_ack) begin
        c++;
        if (c >= ack_dly) begin aer_ack = 1'b1; c = 0; end
      end else if (!aer_req && aer_ack && resp_mode != R_STUCK) begin
        c++;
        if (c >= rel_dly) begin aer_ack = 1'b0; c = 0; end
      end else begin
        c = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (fifo_rd_en) begin
        rd_cnt++;
        chk("rd_single_pulse", 32'(prev_rd), 32'd0);
        chk("rd_not_empty", 32'(fifo_empty), 32'd0);
      end
      if (aer_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got req with addr 0x%0h, expected no request", aer_addr);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          chk("sb_addr", 32'(aer_addr), 32'(e));
        end
        chk("req_after_ack_low", 32'(ack_low_cnt >= 2), 32'd1);
      end
      if (aer_req && prev_req) chk("addr_stable_req", 32'(aer_addr), 32'(prev_addr));
    end
    ack_low_cnt = aer_ack ? 0 : ack_low_cnt + 1;
    prev_req  = aer_req;
    prev_rd   = fifo_rd_en;
    prev_addr = aer_addr;
  end

  // ---------------- driver helpers ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_event_done(input string name);
    int k;
    k = 0;
    while (!busy && k < 60) begin @(negedge clk); k++; end
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    chk({name, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_rd(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!fifo_rd_en && k < 60) begin @(negedge clk); k++; end
    chk({name, "_rd_seen"}, 32'(fifo_rd_en), 32'd1);
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!aer_req && k < 60) begin @(negedge clk); k++; end
    chk({name, "_req_seen"}, 32'(aer_req), 32'd1);
  endtask

  task automatic wait_ack_low();
    int k;
    k = 0;
    while (aer_ack && k < 80) begin @(negedge clk); k++; end
    chk("ack_released", 32'(aer_ack), 32'd0);
    cycles(3);
  endtask

  task automatic pulse_err_clr(input string name);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk({name, "_err_cleared"}, 32'(err_timeout), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DATA_W-1:0] ev;
    int                a_dly;
    int                r_dly;
    bit                no_ack;
    bit                exp_err;
    int                exp_inc;
  } vec_t;

  vec_t vt[6];

  // ---------------- main sequence ----------------
  initial begin
    int rd0;
    int hi;
    int k;

    vt[0] = '{24'h123456, 1, 1,  1'b0, 1'b0, 1};
    vt[1] = '{24'hFFFFFF, 3, 3,  1'b0, 1'b0, 1};
    vt[2] = '{24'h000000, 10, 2, 1'b0, 1'b0, 1};
    vt[3] = '{24'h5A5A5A, 2, 10, 1'b0, 1'b0, 1};
    vt[4] = '{24'hC3C3C3, 1, 1,  1'b1, 1'b1, 0};
    vt[5] = '{24'h00FF00, 1, 30, 1'b0, 1'b1, 0};

    // ---- test 1: reset values, single transfer and latency ----
    tx_en = 1'b1;
    push_ev(24'hABCDEF);
    cycles(3);
    chk("rst_rd_en",  32'(fifo_rd_en), 32'd0);
    chk("rst_req",    32'(aer_req), 32'd0);
    chk("rst_addr",   32'(aer_addr), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_err",    32'(err_timeout), 32'd0);
    chk("rst_count",  32'(sent_count), 32'd0);
    rst = 1'b1;
    wait_rd("t1");
    @(negedge clk);
    chk("t1_addr_not_yet", 32'(aer_addr), 32'd0);
    @(negedge clk);
    chk("t1_addr_valid", 32'(aer_addr), 32'hABCDEF);
    chk("t1_req_low_setup", 32'(aer_req), 32'd0);
    cycles(SETUP_CYC - 1);
    chk("t1_req_low_last_setup", 32'(aer_req), 32'd0);
    @(negedge clk);
    chk("t1_req_rise", 32'(aer_req), 32'd1);
    wait_event_done("t1");
    exp_sent = 1;
    chk("t1_count", 32'(sent_count), 32'(exp_sent));
    chk("t1_rd_pulses", 32'(rd_cnt), 32'd1);

    // ---- test 2: burst of four with a prompt responder ----
    ack_dly = 1;
    rel_dly = 1;
    rd0 = rd_cnt;
    for (int i = 1; i <= 4; i++) push_ev(DATA_W'(i));
    k = 0;
    while (sent_count != CNT_W'(exp_sent + 4) && k < 400) begin @(negedge clk); k++; end
    exp_sent += 4;
    cycles(2);
    chk("t2_count", 32'(sent_count), 32'(exp_sent));
    chk("t2_rd_pulses", 32'(rd_cnt - rd0), 32'd4);
    chk("t2_last_addr", 32'(aer_addr), 32'h000004);
    chk("t2_idle", 32'(busy), 32'd0);

    // ---- test 3: no ack, REQ timeout; timeout beats a simultaneous clear ----
    resp_mode = R_NONE;
    push_ev(24'h3C3C3C);
    @(negedge clk);
    wait_req("t3");
    err_clr = 1'b1;
    hi = 0;
    while (aer_req && hi < 100) begin @(negedge clk); hi++; end
    chk("t3_req_high_cycles", 32'(hi), 32'(TIMEOUT));
    chk("t3_err_wins_clear", 32'(err_timeout), 32'd1);
    err_clr = 1'b0;
    cycles(2);
    chk("t3_err_sticky", 32'(err_timeout), 32'd1);
    chk("t3_count_unchanged", 32'(sent_count), 32'(exp_sent));
    chk("t3_idle", 32'(busy), 32'd0);
    pulse_err_clr("t3");

    // ---- test 4: ack stuck high after handshake -> REL timeout, then resume ----
    resp_mode = R_STUCK;
    ack_dly = 1;
    rel_dly = 2;
    rd0 = rd_cnt;
    push_ev(24'h0A0A0A);
    wait_event_done("t4a");
    chk("t4_err", 32'(err_timeout), 32'd1);
    chk("t4_count_unchanged", 32'(sent_count), 32'(exp_sent));
    pulse_err_clr("t4");
    push_ev(24'h0B0B0B);
    cycles(30);
    chk("t4_no_pop_while_ack", 32'(rd_cnt - rd0), 32'd1);
    chk("t4_idle_while_ack", 32'(busy), 32'd0);
    resp_mode = R_NORMAL;
    wait_event_done("t4b");
    exp_sent += 1;
    chk("t4_count_resume", 32'(sent_count), 32'(exp_sent));
    chk("t4_addr_resume", 32'(aer_addr), 32'h0B0B0B);
    chk("t4_rd_pulses", 32'(rd_cnt - rd0), 32'd2);

    // ---- test 5: tx_en dropped mid-event ----
    ack_dly = 2;
    rel_dly = 2;
    rd0 = rd_cnt;
    push_ev(24'h555001);
    push_ev(24'h555002);
    wait_rd("t5");
    @(negedge clk);
    tx_en = 1'b0;
    wait_event_done("t5a");
    exp_sent += 1;
    chk("t5_first_done", 32'(sent_count), 32'(exp_sent));
    cycles(20);
    chk("t5_second_held", 32'(rd_cnt - rd0), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);
    tx_en = 1'b1;
    wait_event_done("t5b");
    exp_sent += 1;
    chk("t5_second_done", 32'(sent_count), 32'(exp_sent));
    chk("t5_addr", 32'(aer_addr), 32'h555002);

    // ---- vector table ----
    for (int i = 0; i < 6; i++) begin
      ack_dly = vt[i].a_dly;
      rel_dly = vt[i].r_dly;
      resp_mode = vt[i].no_ack ? R_NONE : R_NORMAL;
      push_ev(vt[i].ev);
      wait_event_done($sformatf("vec%0d", i));
      exp_sent += vt[i].exp_inc;
      chk($sformatf("vec%0d_err", i), 32'(err_timeout), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_count", i), 32'(sent_count), 32'(exp_sent));
      chk($sformatf("vec%0d_addr", i), 32'(aer_addr), 32'(vt[i].ev));
      if (vt[i].exp_err) pulse_err_clr($sformatf("vec%0d", i));
      resp_mode = R_NORMAL;
      wait_ack_low();
    end

    // ---- randomized burst: every pushed word goes out once, in order ----
    rd0 = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      push_ev(DATA_W'($urandom));
      ack_dly = $urandom_range(1, 5);
      rel_dly = $urandom_range(1, 5);
      for (int g = 0; g < int'($urandom_range(0, 12)); g++) begin
        tx_en = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
    end
    tx_en = 1'b1;
    exp_sent += 20;
    k = 0;
    while (sent_count != CNT_W'(exp_sent) && k < 4000) begin @(negedge clk); k++; end
    cycles(2);
    chk("rand_count", 32'(sent_count), 32'(exp_sent));
    chk("rand_rd_pulses", 32'(rd_cnt - rd0), 32'd20);
    chk("rand_no_err", 32'(err_timeout), 32'd0);

    // ---- test 6: async reset while req is high ----
    resp_mode = R_NONE;
    push_ev(24'h666666);
    @(negedge clk);
    wait_req("t6");
    cycles(3);
    rst = 1'b0;
    #1;
    chk("t6_req_reset", 32'(aer_req), 32'd0);
    chk("t6_addr_reset", 32'(aer_addr), 32'd0);
    chk("t6_count_reset", 32'(sent_count), 32'd0);
    chk("t6_busy_reset", 32'(busy), 32'd0);
    exp_sent = 0;
    resp_mode = R_NORMAL;
    cycles(3);
    rst = 1'b1;
    push_ev(24'h777777);
    wait_event_done("t6");
    exp_sent += 1;
    chk("t6_count_after", 32'(sent_count), 32'(exp_sent));
    chk("t6_addr_after", 32'(aer_addr), 32'h777777);

    cycles(5);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
